debouncer_bank: RTL and testbench
=================================

Name: debouncer_bank

Overview:
Parametrised multi-channel button debouncer. It is the successor to the single-channel fixed-count debouncer. Each channel gets:
- a configurable-depth input synchroniser
- a debounce length that can be changed at runtime
- registered rise and fall event pulses
- a long-press detector

It sits between raw board buttons/switches and the control logic, replacing per-button debouncer instances.

Parameters:
CHANNELS, 4, number of independent input channels
CNT_W, 11, width of the debounce counter and of the debounce_len port
SYNC_STAGES, 2, flip-flops in each input synchroniser (legal values >= 2)
RESET_LEVEL, 0, value loaded into synchronisers and db_out on reset (idle button level)
HOLD_W, 16, width of the long-press counter
HOLD_CYCLES, 40000, cycles db_out must stay 1 before long_press fires (1..2^HOLD_W-1)

Ports:
clk  in  1  system clock; all state is updated on the rising edge
n_reset  in  1  reset; synchronous, active-low
button_in  in  CHANNELS  raw asynchronous inputs, one bit per channel
debounce_len  in  CNT_W  number of consecutive stable cycles required; 0 is treated as 1
db_out  out  CHANNELS  debounced level
rise  out  CHANNELS  one-cycle pulse when db_out goes 0->1
fall  out  CHANNELS  one-cycle pulse when db_out goes 1->0
long_press  out  CHANNELS  one-cycle pulse once per press when db_out has been 1 for HOLD_CYCLES cycles
any_event  out  1  registered OR of all rise|fall bits; same cycle as the pulses

Behaviour:
- Reset, evaluated only at a clk edge with n_reset=0:
  - all synchroniser flops <= RESET_LEVEL
  - db_out <= RESET_LEVEL
  - cnt, hold_cnt <= 0
  - rise, fall, long_press, any_event <= 0
  - no event pulse may be generated by reset or by its release.
- Synchroniser: per channel, SYNC_STAGES-deep shift register; sync_q is the last stage.
- Effective length: len_eff = (debounce_len==0) ? 1 : debounce_len. It is sampled every cycle.
- Debounce counter, per channel, per edge:
  - if sync_q == db_out: cnt <= 0.
  - else if cnt >= len_eff-1: db_out <= sync_q, cnt <= 0. Also rise <= sync_q and fall <= ~sync_q for that channel.
  - else: cnt <= cnt+1.
- Counter saturation: cnt never exceeds 2^CNT_W-1.
- Reducing debounce_len mid-count: if cnt >= new len_eff-1, the next differing cycle commits immediately (>= comparison).
- Latency: button_in change sampled at edge k with no further bounce gives db_out change at edge k+SYNC_STAGES+len_eff-1.
- Bounce: any cycle where sync_q returns to db_out clears cnt, so the stable run restarts.
- Pulses:
  - rise, fall, long_press are asserted for exactly one cycle.
  - they are registered and coincident with the db_out update.
  - they are deasserted on every other cycle.
- Long press, per channel:
  - if db_out==0: hold_cnt <= 0, armed.
  - if db_out==1 and hold_cnt < HOLD_CYCLES: hold_cnt <= hold_cnt+1.
  - long_press pulses on the edge where hold_cnt goes HOLD_CYCLES-1 -> HOLD_CYCLES. It then saturates with no further pulse until db_out returns to 0.
  - the cycle db_out rises counts as hold cycle 0.
- Channels are fully independent. Simultaneous events on several channels each pulse in the same cycle, and any_event is asserted once.
- Reset mid-count or mid-hold aborts all channels with no pulse. After release, a held-high input must debounce again from cnt=0.
- Implementation: one generate loop over channels, each with the sync chain, cnt, hold_cnt and pulse regs. No combinational path from button_in to any output.

Test Plan:
1. Reset with button_in=4'hF, RESET_LEVEL=0, then release n_reset; debounce_len=4. Expected: no pulse for 2 cycles after release. db_out[i]=1 and rise=4'hF appear at edge 5 after the first sampled edge, with any_event=1 for one cycle.
2. Channel 0 bounce, debounce_len=4: 1,1,0,1,1,1,1 on consecutive cycles. Expected: cnt clears on the 0. db_out[0] rises only after the final 4-cycle stable run, with exactly one rise[0] pulse.
3. Release of channel 0 from stable 1 to 0, debounce_len=4. Expected: fall[0] pulses once, SYNC_STAGES+3 edges after the sampled change; rise stays 0.
4. debounce_len=0, single-cycle glitch on channel 1. Expected: treated as len 1, so db_out[1] follows with 2-edge latency; rise[1] then fall[1] each pulse once.
5. HOLD_CYCLES=10, channel 2 held for 25 cycles after debounce. Expected: exactly one long_press[2] pulse, 10 cycles after rise[2]. After release and a new press, it pulses again.
6. n_reset=0 asserted while channel 3 is mid-count (cnt=2) and while channel 2 is mid-hold. Expected: all outputs 0 and no pulses. After release, channel 3 needs the full debounce_len stable run.

Source files
------------

// File: rtl/debouncer_bank.sv
// debouncer_bank: multi-channel button debouncer.
// Each channel has its own input synchroniser, a debounce counter whose
// length can change at runtime, registered rise/fall pulses and a
// long-press detector. No output depends combinationally on button_in.
//
// Handshake: none. button_in is sampled every clock; every output is a
// registered level (db_out) or a one-cycle registered pulse (rise, fall,
// long_press, any_event) that lines up with the db_out update it belongs to.
module debouncer_bank #(
   parameter int unsigned CHANNELS    = 4,
   parameter int unsigned CNT_W       = 11,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RESET_LEVEL = 1'b0,
   parameter int unsigned HOLD_W      = 16,
   parameter int unsigned HOLD_CYCLES = 40000
) (
   input  logic                clk,
   input  logic                n_reset,
   input  logic [CHANNELS-1:0] button_in,
   input  logic [CNT_W-1:0]    debounce_len,
   output logic [CHANNELS-1:0] db_out,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CHANNELS-1:0] long_press,
   output logic                any_event
);

   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   // len_eff - 1, with a programmed length of 0 behaving like 1.
   // Comparing cnt >= len_m1 means a shortened length commits at once.
   logic [CNT_W-1:0] len_m1;
   assign len_m1 = (debounce_len == '0) ? '0 : (debounce_len - CNT_W'(1));

   // Per-channel rise|fall next-state bits, merged into any_event.
   logic [CHANNELS-1:0] event_d;
   logic                any_event_q;

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      logic                   sync_bit;
      logic [CNT_W-1:0]       cnt_q, cnt_d;
      logic                   db_q, db_d;
      logic                   rise_q, rise_d;
      logic                   fall_q, fall_d;
      logic [HOLD_W-1:0]      hold_q, hold_d;
      logic                   lp_q, lp_d;

      // Last synchroniser stage is the only view of the raw input.
      assign sync_bit = sync_q[SYNC_STAGES-1];

      // Shift the raw input into the synchroniser chain.
      always_comb begin
         sync_d = {sync_q[SYNC_STAGES-2:0], button_in[ch]};
      end

      // Debounce: count cycles the synchronised input differs from db_out,
      // commit when the run reaches len_eff, restart on any bounce back.
      always_comb begin
         cnt_d  = cnt_q;
         db_d   = db_q;
         rise_d = 1'b0;
         fall_d = 1'b0;
         if (sync_bit == db_q) begin
            cnt_d = '0;
         end else if (cnt_q >= len_m1) begin
            db_d   = sync_bit;
            cnt_d  = '0;
            rise_d = sync_bit;
            fall_d = ~sync_bit;
         end else begin
            // cnt_q < len_m1 <= 2^CNT_W-2 here, so the increment cannot wrap.
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      // Long press: count cycles spent high, pulse once on reaching
      // HOLD_CYCLES, then hold the count until db_out drops.
      always_comb begin
         hold_d = hold_q;
         lp_d   = 1'b0;
         if (!db_q) begin
            hold_d = '0;
         end else if (hold_q < HOLD_MAX) begin
            hold_d = hold_q + HOLD_W'(1);
            lp_d   = (hold_q == HOLD_LAST);
         end
      end

      // Channel state register with synchronous active-low reset.
      always_ff @(posedge clk) begin
         if (!n_reset) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
            cnt_q  <= '0;
            db_q   <= RESET_LEVEL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            hold_q <= '0;
            lp_q   <= 1'b0;
         end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            hold_q <= hold_d;
            lp_q   <= lp_d;
         end
      end

      assign event_d[ch]    = rise_d | fall_d;
      assign db_out[ch]     = db_q;
      assign rise[ch]       = rise_q;
      assign fall[ch]       = fall_q;
      assign long_press[ch] = lp_q;
   end

   // any_event is registered from the same next-state bits as the pulses,
   // so it lands in the same cycle as them.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         any_event_q <= 1'b0;
      end else begin
         any_event_q <= |event_d;
      end
   end

   assign any_event = any_event_q;

endmodule

// File: tb/tb_debouncer_bank.sv
// tb_debouncer_bank: directed table, hand-written corner sequences and a
// randomized run compared against a behavioural model of the debouncer.
module tb_debouncer_bank;

   localparam int   CH          = 4;
   localparam int   CNT_W       = 11;
   localparam int   SYNC        = 2;
   localparam logic RESET_LEVEL = 1'b0;
   localparam int   HOLD_W      = 16;
   localparam int   HOLD        = 10;
   localparam int   W           = 4 * CH + 1;

   logic             clk;
   logic             n_reset;
   logic [CH-1:0]    button_in;
   logic [CNT_W-1:0] debounce_len;
   logic [CH-1:0]    db_out, rise, fall, long_press;
   logic             any_event;

   int checks = 0;
   int errors = 0;

   debouncer_bank #(
      .CHANNELS(CH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC),
      .RESET_LEVEL(RESET_LEVEL), .HOLD_W(HOLD_W), .HOLD_CYCLES(HOLD)
   ) dut (
      .clk(clk), .n_reset(n_reset), .button_in(button_in),
      .debounce_len(debounce_len), .db_out(db_out), .rise(rise),
      .fall(fall), .long_press(long_press), .any_event(any_event)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model + scoreboard ----------------
   // Model view: the input reaches the debouncer SYNC edges late; a level
   // change is accepted once it has differed from db for len_eff consecutive
   // edges; long press fires when the level has been high for exactly HOLD
   // edges after the rise edge.
   logic [CH-1:0] m_pipe[$];      // index 0 = most recently sampled input
   logic [CH-1:0] m_db;
   int            m_run[CH];
   int            m_high[CH];
   logic [W-1:0]  exp_q[$];

   task automatic model_edge(input logic nr, input logic [CH-1:0] b, input logic [CNT_W-1:0] l);
      logic [CH-1:0] sync, rs, fl, lp;
      int            len_eff;
      rs = '0; fl = '0; lp = '0;
      if (!nr) begin
         m_pipe.delete();
         for (int s = 0; s < SYNC; s++) m_pipe.push_back({CH{RESET_LEVEL}});
         m_db = {CH{RESET_LEVEL}};
         for (int c = 0; c < CH; c++) begin
            m_run[c]  = 0;
            m_high[c] = 0;
         end
      end else begin
         sync    = m_pipe[SYNC-1];
         len_eff = (l == 0) ? 1 : int'(l);
         for (int c = 0; c < CH; c++) begin
            if (m_db[c]) begin
               m_high[c]++;
               if (m_high[c] == HOLD) lp[c] = 1'b1;
            end else begin
               m_high[c] = 0;
            end
            if (sync[c] == m_db[c]) begin
               m_run[c] = 0;
            end else begin
               m_run[c]++;
               if (m_run[c] >= len_eff) begin
                  m_db[c]  = sync[c];
                  m_run[c] = 0;
                  rs[c]    = sync[c];
                  fl[c]    = ~sync[c];
               end
            end
         end
         m_pipe.push_front(b);
         void'(m_pipe.pop_back());
      end
      exp_q.push_back({m_db, rs, fl, lp, |(rs | fl)});
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check_model();
      logic [W-1:0] got, exp;
      got = {db_out, rise, fall, long_press, any_event};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL model_queue empty");
      end else begin
         exp = exp_q.pop_front();
         if (got !== exp) begin
            errors++;
            $display("FAIL model t=%0t got %h expected %h", $time, got, exp);
         end
      end
   endtask

   // ---------------- driver ----------------
   // Drive on the falling edge, let the model take the rising edge, sample 1ns later.
   task automatic tick(input logic nr, input logic [CH-1:0] b, input logic [CNT_W-1:0] l);
      @(negedge clk);
      n_reset      = nr;
      button_in    = b;
      debounce_len = l;
      @(posedge clk);
      model_edge(nr, b, l);
      #1;
      check_model();
   endtask

   // ---------------- directed table ----------------
   typedef struct packed {
      logic             nr;
      logic [CH-1:0]    btn;
      logic [CNT_W-1:0] len;
      logic [CH-1:0]    db;
      logic [CH-1:0]    rs;
      logic [CH-1:0]    fl;
      logic             any;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int rise_t, long_t, long_n, cnt_a, cnt_b, fall_t;
      logic [CH-1:0]    rb;
      logic [CNT_W-1:0] rl;
      logic [6:0]       pat;

      n_reset      = 1'b0;
      button_in    = '0;
      debounce_len = 11'd4;

      // Reset with all buttons held, release, first debounce of all channels.
      vecs[0] = '{1'b0, 4'hF, 11'd4, 4'h0, 4'h0, 4'h0, 1'b0};
      vecs[1] = '{1'b0, 4'hF, 11'd4, 4'h0, 4'h0, 4'h0, 1'b0};
      vecs[2] = '{1'b1, 4'hF, 11'd4, 4'h0, 4'h0, 4'h0, 1'b0};
      vecs[3] = '{1'b1, 4'hF, 11'd4, 4'h0, 4'h0, 4'h0, 1'b0};
      vecs[4] = '{1'b1, 4'hF, 11'd4, 4'h0, 4'h0, 4'h0, 1'b0};
      vecs[5] = '{1'b1, 4'hF, 11'd4, 4'h0, 4'h0, 4'h0, 1'b0};
      vecs[6] = '{1'b1, 4'hF, 11'd4, 4'h0, 4'h0, 4'h0, 1'b0};
      vecs[7] = '{1'b1, 4'hF, 11'd4, 4'hF, 4'hF, 4'h0, 1'b1};
      vecs[8] = '{1'b1, 4'hF, 11'd4, 4'hF, 4'h0, 4'h0, 1'b0};
      vecs[9] = '{1'b1, 4'hF, 11'd4, 4'hF, 4'h0, 4'h0, 1'b0};

      for (int i = 0; i < 10; i++) begin
         tick(vecs[i].nr, vecs[i].btn, vecs[i].len);
         check($sformatf("t1_db[%0d]", i),   db_out,    vecs[i].db);
         check($sformatf("t1_rise[%0d]", i), rise,      vecs[i].rs);
         check($sformatf("t1_fall[%0d]", i), fall,      vecs[i].fl);
         check($sformatf("t1_any[%0d]", i),  any_event, vecs[i].any);
      end

      // Rise was at edge 6 (table row 7); long_press at edge 16 for all channels.
      for (int j = 1; j <= 8; j++) begin
         tick(1'b1, 4'hF, 11'd4);
         check($sformatf("t1_long[%0d]", j), long_press, (j == 8) ? 4'hF : 4'h0);
      end
      check("t1_long_no_any", any_event, 1'b0);

      // Release channel 0: fall 5 edges after the sampled change, no rise.
      fall_t = -1; cnt_a = 0; cnt_b = 0;
      for (int j = 1; j <= 8; j++) begin
         tick(1'b1, 4'hE, 11'd4);
         if (fall[0]) begin cnt_a++; fall_t = j; end
         if (rise != 4'h0) cnt_b++;
      end
      check("t3_fall_count", cnt_a, 1);
      check("t3_fall_tick", fall_t, 6);
      check("t3_no_rise", cnt_b, 0);
      check("t3_db0", db_out[0], 1'b0);

      // Channel 0 bounce 1,1,0,1,1,1,1: the 0 restarts the run.
      pat = 7'b1111011;   // bit j = value at tick j+1
      rise_t = -1; cnt_a = 0;
      for (int j = 1; j <= 12; j++) begin
         tick(1'b1, {3'b111, (j <= 7) ? pat[j-1] : 1'b1}, 11'd4);
         if (rise[0]) begin cnt_a++; rise_t = j; end
      end
      check("t2_rise_count", cnt_a, 1);
      check("t2_rise_tick", rise_t, 9);
      check("t2_db0", db_out[0], 1'b1);

      // debounce_len=0 acts as 1: one-cycle glitch on channel 1 passes through.
      tick(1'b1, 4'hD, 11'd0);
      check("t4_quiet1", {rise[1], fall[1]}, 2'b00);
      tick(1'b1, 4'hF, 11'd0);
      check("t4_quiet2", {rise[1], fall[1]}, 2'b00);
      tick(1'b1, 4'hF, 11'd0);
      check("t4_fall1", {db_out[1], rise[1], fall[1]}, 3'b001);
      tick(1'b1, 4'hF, 11'd0);
      check("t4_rise1", {db_out[1], rise[1], fall[1]}, 3'b110);

      // Long press on channel 2, then again after release and re-press.
      repeat (8) tick(1'b1, 4'hB, 11'd4);
      rise_t = -1; long_t = -1; long_n = 0;
      for (int j = 1; j <= 60; j++) begin
         tick(1'b1, 4'hF, 11'd4);
         if (rise[2] && rise_t < 0) rise_t = j;
         if (long_press[2]) begin long_n++; long_t = j; end
         if (rise_t > 0 && j >= rise_t + 25) break;
      end
      check("t5_rise_seen", (rise_t > 0), 1);
      check("t5_long_count", long_n, 1);
      check("t5_long_delay", long_t - rise_t, HOLD);
      repeat (8) tick(1'b1, 4'hB, 11'd4);
      long_n = 0;
      for (int j = 1; j <= 30; j++) begin
         tick(1'b1, 4'hF, 11'd4);
         if (long_press[2]) long_n++;
      end
      check("t5_long_again", long_n, 1);

      // Reset while channel 3 is mid-count and channel 2 is mid-hold.
      repeat (8) tick(1'b1, 4'h3, 11'd4);
      for (int j = 1; j <= 6; j++) tick(1'b1, 4'h7, 11'd4);
      check("t6_rise2", rise[2], 1'b1);
      cnt_a = 0;
      for (int j = 1; j <= 4; j++) begin
         tick(1'b1, 4'hF, 11'd4);
         if (rise[3]) cnt_a++;
      end
      check("t6_ch3_pending", cnt_a, 0);
      for (int j = 1; j <= 2; j++) begin
         tick(1'b0, 4'hF, 11'd4);
         check($sformatf("t6_reset_out[%0d]", j), {db_out, rise, fall, long_press, any_event}, 0);
      end
      cnt_a = 0;
      for (int j = 1; j <= 5; j++) begin
         tick(1'b1, 4'hF, 11'd4);
         if ((rise | fall | long_press) != 4'h0 || any_event) cnt_a++;
      end
      check("t6_no_early_pulse", cnt_a, 0);
      tick(1'b1, 4'hF, 11'd4);
      check("t6_rise_all", rise, 4'hF);
      check("t6_db_all", db_out, 4'hF);

      // Randomized run: alternating noisy and calm phases, occasional
      // runtime length changes and rare resets, all checked by the model.
      rb = 4'hF;
      rl = 11'd4;
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < CH; c++) begin
            if (((n / 200) % 2) == 0) begin
               if ($urandom_range(0, 7) == 0) rb[c] = ~rb[c];
            end else begin
               if ($urandom_range(0, 63) == 0) rb[c] = ~rb[c];
            end
         end
         if ($urandom_range(0, 40) == 0) rl = CNT_W'($urandom_range(0, 6));
         tick(($urandom_range(0, 499) != 0), rb, rl);
      end

      check("final_queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
